// File: rtl/regfile_writeback_pkg.sv
// Shared definitions for the EV22 register-file write side: register indices,
// default widths and the output-port handshake state.
package regfile_writeback_pkg;

    localparam int DATA_W = 16;
    localparam int SEL_W  = 6;

    localparam int R_PI0  = 28;
    localparam int R_PI1  = 29;
    localparam int R_PO0  = 30;
    localparam int R_PO1  = 31;
    localparam int R_R32  = 32;
    localparam int R_R33  = 33;
    localparam int R_WREG = 34;

    typedef enum logic {
        IDLE   = 1'b0,
        STROBE = 1'b1
    } strobe_state_e;

    function automatic logic is_out_port(input logic [31:0] sel);
        return (sel == 32'(R_PO0)) || (sel == 32'(R_PO1));
    endfunction

endpackage

// File: rtl/regfile_writeback_port_strobe_ctrl.sv
// Output-port handshake: holds po_strobe for the addressed port until po_ack
// arrives or ACK_TIMEOUT strobe cycles elapse, then returns to IDLE.
module port_strobe_ctrl
    import regfile_writeback_pkg::*;
#(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       start_port,
    input  logic [1:0] po_ack,
    output logic       busy,
    output logic [1:0] po_strobe,
    output logic       err_timeout
);

    localparam int CNT_W = 8;

    strobe_state_e    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             port_q, port_d;
    logic [1:0]       strobe_q, strobe_d;
    logic             err_timeout_q, err_timeout_d;

    always_comb begin
        // NOTE: every _d is given a default before any branch so no latch is inferred.
        state_d       = state_q;
        cnt_d         = cnt_q;
        port_d        = port_q;
        strobe_d      = strobe_q;
        err_timeout_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = STROBE;
                    port_d   = start_port;
                    cnt_d    = '0;
                    strobe_d = start_port ? 2'b10 : 2'b01;
                end
            end
            STROBE: begin
                // Acknowledge is tested first so it wins over a coincident timeout.
                if (po_ack[port_q]) begin
                    state_d  = IDLE;
                    cnt_d    = '0;
                    strobe_d = 2'b00;
                end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
                    state_d       = IDLE;
                    cnt_d         = '0;
                    strobe_d      = 2'b00;
                    err_timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d  = IDLE;
                strobe_d = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state is written with <= only; all next-state math is in always_comb.
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            port_q        <= 1'b0;
            strobe_q      <= 2'b00;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            port_q        <= port_d;
            strobe_q      <= strobe_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign busy        = (state_q == STROBE);
    assign po_strobe   = strobe_q;
    assign err_timeout = err_timeout_q;

endmodule

// File: rtl/regfile_writeback.sv
// EV22 register-file write side: decodes bus C writes into r0..r27, r32..r34
// and the output ports, and synchronises the input ports into r28/r29.
module regfile_writeback #(
    parameter int DATA_W      = regfile_writeback_pkg::DATA_W,
    parameter int SEL_W       = regfile_writeback_pkg::SEL_W,
    parameter int NUM_GPR     = 28,
    parameter int SYNC_STAGES = 2,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [SEL_W-1:0]          Sel_C,
    input  logic [DATA_W-1:0]         Data_C,
    input  logic [DATA_W-1:0]         pi0_in,
    input  logic [DATA_W-1:0]         pi1_in,
    output logic [NUM_GPR*DATA_W-1:0] gpr_flat,
    output logic [DATA_W-1:0]         r28,
    output logic [DATA_W-1:0]         r29,
    output logic [DATA_W-1:0]         r32,
    output logic [DATA_W-1:0]         r33,
    output logic [DATA_W-1:0]         Working_Register,
    output logic [DATA_W-1:0]         po0,
    output logic [DATA_W-1:0]         po1,
    output logic [1:0]                po_strobe,
    input  logic [1:0]                po_ack,
    output logic                      err_ro,
    output logic                      err_illegal,
    output logic                      err_timeout
);

    import regfile_writeback_pkg::*;

    logic [DATA_W-1:0] gpr_q [NUM_GPR];
    logic [DATA_W-1:0] gpr_d [NUM_GPR];
    logic [DATA_W-1:0] r32_q, r32_d, r33_q, r33_d, wreg_q, wreg_d;
    logic [DATA_W-1:0] po0_q, po0_d, po1_q, po1_d;
    logic [DATA_W-1:0] pi0_sync_q [SYNC_STAGES];
    logic [DATA_W-1:0] pi0_sync_d [SYNC_STAGES];
    logic [DATA_W-1:0] pi1_sync_q [SYNC_STAGES];
    logic [DATA_W-1:0] pi1_sync_d [SYNC_STAGES];
    logic              err_ro_q, err_ro_d, err_illegal_q, err_illegal_d;

    logic        accept;
    logic        busy;
    logic        po_start;
    logic        po_port;
    logic [31:0] sel_idx;

    assign wr_ready = !busy;
    assign accept   = wr_valid && wr_ready;
    assign sel_idx  = 32'(Sel_C);
    assign po_start = accept && is_out_port(sel_idx);
    assign po_port  = (sel_idx == 32'(R_PO1));

    always_comb begin
        gpr_d         = gpr_q;
        r32_d         = r32_q;
        r33_d         = r33_q;
        wreg_d        = wreg_q;
        po0_d         = po0_q;
        po1_d         = po1_q;
        err_ro_d      = 1'b0;
        err_illegal_d = 1'b0;
        if (accept) begin
            if (sel_idx < 32'(NUM_GPR)) begin
                for (int i = 0; i < NUM_GPR; i++) begin
                    if (sel_idx == 32'(i)) gpr_d[i] = Data_C;
                end
            end else if (sel_idx == 32'(R_PI0) || sel_idx == 32'(R_PI1)) begin
                err_ro_d = 1'b1;
            end else if (sel_idx == 32'(R_PO0)) begin
                po0_d = Data_C;
            end else if (sel_idx == 32'(R_PO1)) begin
                po1_d = Data_C;
            end else if (sel_idx == 32'(R_R32)) begin
                r32_d = Data_C;
            end else if (sel_idx == 32'(R_R33)) begin
                r33_d = Data_C;
            end else if (sel_idx == 32'(R_WREG)) begin
                wreg_d = Data_C;
            end else begin
                err_illegal_d = 1'b1;
            end
        end
    end

    always_comb begin
        pi0_sync_d[0] = pi0_in;
        pi1_sync_d[0] = pi1_in;
        for (int s = 1; s < SYNC_STAGES; s++) begin
            pi0_sync_d[s] = pi0_sync_q[s-1];
            pi1_sync_d[s] = pi1_sync_q[s-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the register array is reset too: software relies on r0..r27 reading zero after reset.
            for (int i = 0; i < NUM_GPR; i++) gpr_q[i] <= '0;
            for (int s = 0; s < SYNC_STAGES; s++) begin
                pi0_sync_q[s] <= '0;
                pi1_sync_q[s] <= '0;
            end
            r32_q         <= '0;
            r33_q         <= '0;
            wreg_q        <= '0;
            po0_q         <= '0;
            po1_q         <= '0;
            err_ro_q      <= 1'b0;
            err_illegal_q <= 1'b0;
        end else begin
            gpr_q         <= gpr_d;
            pi0_sync_q    <= pi0_sync_d;
            pi1_sync_q    <= pi1_sync_d;
            r32_q         <= r32_d;
            r33_q         <= r33_d;
            wreg_q        <= wreg_d;
            po0_q         <= po0_d;
            po1_q         <= po1_d;
            err_ro_q      <= err_ro_d;
            err_illegal_q <= err_illegal_d;
        end
    end

    port_strobe_ctrl #(
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_port_strobe_ctrl (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (po_start),
        .start_port  (po_port),
        .po_ack      (po_ack),
        .busy        (busy),
        .po_strobe   (po_strobe),
        .err_timeout (err_timeout)
    );

    for (genvar g = 0; g < NUM_GPR; g++) begin : g_flat
        assign gpr_flat[g*DATA_W +: DATA_W] = gpr_q[g];
    end

    assign r28              = pi0_sync_q[SYNC_STAGES-1];
    assign r29              = pi1_sync_q[SYNC_STAGES-1];
    assign r32              = r32_q;
    assign r33              = r33_q;
    assign Working_Register = wreg_q;
    assign po0              = po0_q;
    assign po1              = po1_q;
    assign err_ro           = err_ro_q;
    assign err_illegal      = err_illegal_q;

endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
Write side of the EV22 register file; the counterpart of the Data_A/Data_B read multiplexer.
- Accepts one result word per handshake from the execute stage (bus C) and writes it into the addressed register (r0..r27, r32, r33, Working_Register/r34).
- Drives the two output ports PO0/PO1 (r30/r31) through a strobe/ack handshake with timeout.
- Synchronises the asynchronous input ports PI0/PI1 into r28/r29 for the read multiplexer.

Parameters:
DATA_W, 16, register width
SEL_W, 6, width of the destination select Sel_C
NUM_GPR, 28, general registers r0..NUM_GPR-1
SYNC_STAGES, 2, flop stages on PI0/PI1 (minimum 2)
ACK_TIMEOUT, 255, cycles to wait for po_ack before abandoning a port write (1..255)

Ports:
clk  in  1  single system clock, rising edge
rst_n  in  1  synchronous, active-low reset
wr_valid  in  1  write request from execute stage
wr_ready  out  1  block can accept a write this cycle
Sel_C  in  SEL_W  destination register index
Data_C  in  DATA_W  write data
pi0_in  in  DATA_W  asynchronous input port 0
pi1_in  in  DATA_W  asynchronous input port 1
gpr_flat  out  NUM_GPR*DATA_W  r0..r27 state; rN occupies bits [N*16+15:N*16]
r28  out  DATA_W  synchronised PI0
r29  out  DATA_W  synchronised PI1
r32  out  DATA_W  register r32
r33  out  DATA_W  register r33
Working_Register  out  DATA_W  register r34
po0  out  DATA_W  output port 0 (r30)
po1  out  DATA_W  output port 1 (r31)
po_strobe  out  2  bit i high while a write to port i awaits acknowledgement
po_ack  in  2  peripheral acknowledge, bit i for port i
err_ro  out  1  one-cycle pulse: write to r28/r29 dropped
err_illegal  out  1  one-cycle pulse: Sel_C 35..63 dropped
err_timeout  out  1  one-cycle pulse: port acknowledge timed out

Behaviour:
- Reset (rst_n low at a rising edge) clears:
  - all registers, po0/po1 and the synchroniser flops to 0;
  - po_strobe and all err_* to 0;
  - the FSM to IDLE and the timeout counter to 0.
- wr_ready is 1 in the first cycle after reset.
- Accept: wr_valid && wr_ready at a rising edge. The register updates at that edge and is visible on outputs in the next cycle (latency 1). No write-through to the read multiplexer.
- Decode of an accepted Sel_C:
  - 0..27: write gpr_flat slot.
  - 28, 29: dropped; err_ro pulses next cycle.
  - 30, 31: load po0/po1; FSM enters STROBE.
  - 32, 33: write r32, r33.
  - 34: write Working_Register.
  - 35..63: dropped; err_illegal pulses.
- FSM IDLE: wr_ready=1, po_strobe=0.
- FSM STROBE:
  - wr_ready=0. GPR writes are also stalled (in-order completion).
  - po_strobe bit for the target port =1; the counter increments each cycle.
  - po_ack bit of the target port seen high: return to IDLE next cycle, strobe drops. The ack bit of the other port is ignored.
  - Counter reaches ACK_TIMEOUT without ack: return to IDLE, err_timeout pulses, po value retained.
  - Ack and timeout in the same cycle: ack wins, no error.
- po_ack already high on the cycle STROBE is entered: completes after exactly one strobe cycle.
- PI path: each of pi0_in/pi1_in passes through SYNC_STAGES flops. Reset clears them; after reset release r28 reflects pi0_in SYNC_STAGES cycles later.
- Reset asserted during STROBE: strobe drops and the FSM returns to IDLE at that edge; po0/po1 clear.
- wr_valid may drop without acceptance; no request is stored while wr_ready=0.

Decomposition:
- Shared package: EV22 register index constants (R_PI0=28, R_PI1=29, R_PO0=30, R_PO1=31, R_R32=32, R_R33=33, R_WREG=34), DATA_W, SEL_W and the FSM state typedef (IDLE, STROBE).
- One sub-module, port_strobe_ctrl: the STROBE FSM, timeout counter and po_strobe/err_timeout generation for the two output ports.
- Decode and register storage stay in the top module.

Test Plan:
- Reset, then write Sel_C=5, Data_C=16'hA5A5 -> gpr_flat r5 = A5A5 one cycle later; all other registers remain 0.
- Write Sel_C=34, Data_C=16'h1234, then Sel_C=33, Data_C=16'hBEEF on consecutive cycles -> Working_Register=1234, r33=BEEF; wr_ready stays 1.
- Write Sel_C=30, Data_C=16'h00FF; assert po_ack[0] 3 cycles later -> po0=00FF, po_strobe[0] high for 3 cycles, wr_ready low meanwhile, no err_timeout.
- Write Sel_C=31 with ACK_TIMEOUT=4 and po_ack held 0 -> err_timeout pulses once after 4 strobe cycles; po1 retained; wr_ready returns to 1.
- Write Sel_C=28, then Sel_C=40 -> err_ro pulse, then err_illegal pulse; no register changes.
- Hold pi1_in=16'h0F0F -> r29=0F0F after 2 cycles; rst_n low mid-STROBE -> po_strobe=0, po0=0 at the next edge.
